zxuno_regbus_ctrl: RTL and testbench
====================================

// Module: zxuno_regbus_ctrl
//
// PURPOSE
//   Front-end controller for the ZX-Uno extended register bus. Decodes Z80 I/O
//   cycles to the address port (FC3Bh) and data port (FD3Bh), holds the current
//   register address, and generates the strobes that the register peripherals
//   (core ID, scandoubler, keymap, etc.) consume. Arbitrates the peripherals'
//   read data onto a single byte with fixed priority and flags contention.
//
// PARAMETERS
//   NSRC      4        number of peripheral read sources (1..16)
//   ADDR_PORT 16'hFC3B I/O port that selects the register address
//   DATA_PORT 16'hFD3B I/O port that reads/writes the selected register
//
// PORTS
//   clk             in   1       system clock; all Z80 bus inputs are synchronous to it
//   rst_n           in   1       asynchronous reset, active low
//   a               in   16      Z80 address bus
//   iorq_n          in   1       Z80 IORQ, active low
//   rd_n            in   1       Z80 RD, active low
//   wr_n            in   1       Z80 WR, active low
//   din             in   8       Z80 data bus (write data)
//   per_dout        in   8*NSRC  peripheral read data, source i at [8*i+7:8*i]
//   per_oe_n        in   NSRC    peripheral output enables, active low
//   zxuno_addr      out  8       currently selected register address
//   zxuno_regrd     out  1       level: data-port read cycle in progress
//   zxuno_regwr     out  1       level: data-port write cycle in progress
//   regaddr_changed out  1       1-cycle pulse after zxuno_addr is written
//   dout            out  8       byte returned to the CPU
//   oe_n            out  1       active low: drive dout onto the CPU bus
//   conflict        out  1       sticky: >1 source enabled during one read
//
// BEHAVIOUR
//   Reset (rst_n low, async): zxuno_addr=8'h00, regrd=regwr=0, regaddr_changed=0,
//     conflict=0, FSM=IDLE. oe_n high, dout=8'hFF.
//   Decode (comb): aw = !iorq_n&!wr_n&a==ADDR_PORT; dr/dw same on DATA_PORT with
//     rd_n/wr_n. Full 16-bit compare.
//   FSM, one transition per clk; states IDLE, AWR, DRD, DWR:
//     IDLE -> AWR on aw: zxuno_addr<=din this edge; regaddr_changed=1 next cycle only.
//     IDLE -> DRD on dr: zxuno_regrd=1 from next cycle.
//     IDLE -> DWR on dw: zxuno_regwr=1 from next cycle.
//     AWR/DRD/DWR -> IDLE when iorq_n high; regrd/regwr drop the cycle after.
//     Exactly one action per I/O cycle; din changes within a held AWR are ignored.
//     Priority when several decode terms true in IDLE: aw > dw > dr.
//   Read arbitration (comb, valid while zxuno_regrd=1):
//     selected = lowest index i with per_oe_n[i]=0; dout=per_dout[i]; oe_n=0.
//     No source enabled: oe_n=1, dout=8'hFF. regrd=0: oe_n=1, dout=8'hFF.
//   conflict set on any clk with regrd=1 and >=2 per_oe_n low; cleared only by
//     reset or an address-port write (same edge zxuno_addr loads).
//   Reset mid-cycle: FSM to IDLE; the in-flight cycle is not re-acted on until
//     iorq_n has been seen high (IDLE entered from reset requires iorq_n=1 once).
//   Back-to-back cycles: a new cycle is accepted only from IDLE; minimum one clk
//     of iorq_n high between cycles.
//
// CONFIGURATION
//   ZXUNO_ADDR_READBACK_EN defined: a read of ADDR_PORT (FSM state ARD, same
//     rules as DRD, no regrd strobe) returns oe_n=0, dout=zxuno_addr.
//   Not defined: ADDR_PORT reads are ignored; oe_n stays 1, dout=8'hFF.
//
// TESTING
//   Reset: rst_n low async mid-clock -> all outputs at reset values immediately.
//   OUT (FC3Bh),8'hFF for 3 clks -> zxuno_addr=8'hFF, regaddr_changed high 1 clk.
//   IN (FD3Bh), per_oe_n=4'b1101, per_dout[15:8]=8'h54 -> oe_n=0, dout=8'h54, conflict=0.
//   IN (FD3Bh), per_oe_n=4'b1100 -> dout=source 0 byte, conflict=1; stays 1 until OUT FC3Bh.
//   OUT (FD3Bh),8'h12 for 4 clks -> regwr high 4 clks after 1-clk latency, zxuno_addr unchanged.
//   IN (FC3Bh) after addr=8'h0B -> dout=8'h0B,oe_n=0 with READBACK_EN; oe_n=1 without.

Source files
------------

// File: rtl/zxuno_regbus_ctrl.sv
// zxuno_regbus_ctrl
//   Front-end for the ZX-Uno extended register bus. Decodes Z80 I/O cycles to
//   the address port (ADDR_PORT) and data port (DATA_PORT), keeps the selected
//   register address, produces the read/write level strobes the register
//   peripherals consume, and merges the peripherals' read data onto one byte
//   with fixed lowest-index-wins priority plus a sticky contention flag.
//
//   Optional feature: define ZXUNO_ADDR_READBACK_EN to make reads of ADDR_PORT
//   return the current register address. Without it such reads are ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   a, iorq_n, rd_n,    Z80 bus (synchronous to clk)
//   wr_n, din
//   per_dout, per_oe_n  peripheral read bytes (source i at [8*i+7:8*i]) and
//                       active-low output enables
//   zxuno_addr          selected register address
//   zxuno_regrd/regwr   level strobes while a data-port read/write is active
//   regaddr_changed     one-cycle pulse after zxuno_addr is loaded
//   dout, oe_n          byte for the CPU and its active-low drive enable
//   conflict            sticky: two or more sources enabled during a read
module zxuno_regbus_ctrl #(
  parameter int          NSRC      = 4,
  parameter logic [15:0] ADDR_PORT = 16'hFC3B,
  parameter logic [15:0] DATA_PORT = 16'hFD3B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       a,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        din,
  input  logic [8*NSRC-1:0] per_dout,
  input  logic [NSRC-1:0]   per_oe_n,
  output logic [7:0]        zxuno_addr,
  output logic              zxuno_regrd,
  output logic              zxuno_regwr,
  output logic              regaddr_changed,
  output logic [7:0]        dout,
  output logic              oe_n,
  output logic              conflict
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AWR  = 3'd1,
    S_DRD  = 3'd2,
    S_DWR  = 3'd3,
    S_ARD  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   armed_q;     // iorq_n has been seen high since reset
  logic   aw, dw, dr;
  logic   addr_load;
  logic   src_hit, multi;
  logic [7:0] src_byte;

  assign aw = !iorq_n && !wr_n && (a == ADDR_PORT);
  assign dw = !iorq_n && !wr_n && (a == DATA_PORT);
  assign dr = !iorq_n && !rd_n && (a == DATA_PORT);

`ifdef ZXUNO_ADDR_READBACK_EN
  logic ar;
  assign ar = !iorq_n && !rd_n && (a == ADDR_PORT);
`endif

  // Next state. New cycles start only from IDLE, so one I/O cycle gets
  // exactly one action; active states wait for iorq_n to release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (armed_q) begin
          if (aw)      state_d = S_AWR;
          else if (dw) state_d = S_DWR;
          else if (dr) state_d = S_DRD;
`ifdef ZXUNO_ADDR_READBACK_EN
          else if (ar) state_d = S_ARD;
`endif
        end
      end
      default: if (iorq_n) state_d = S_IDLE;
    endcase
  end

  assign addr_load = (state_q == S_IDLE) && (state_d == S_AWR);

  // Lowest enabled index wins: scan high to low so the last hit sticks.
  always_comb begin
    src_hit  = 1'b0;
    multi    = 1'b0;
    src_byte = 8'hFF;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (!per_oe_n[i]) begin
        if (src_hit) multi = 1'b1;
        src_hit  = 1'b1;
        src_byte = per_dout[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      armed_q         <= 1'b0;
      zxuno_addr      <= 8'h00;
      regaddr_changed <= 1'b0;
      conflict        <= 1'b0;
    end else begin
      state_q         <= state_d;
      if (iorq_n) armed_q <= 1'b1;
      regaddr_changed <= addr_load;
      if (addr_load)
        zxuno_addr <= din;
      // Address-port write clears; regrd is never high in that cycle.
      if (addr_load)
        conflict <= 1'b0;
      else if (zxuno_regrd && multi)
        conflict <= 1'b1;
    end
  end

  assign zxuno_regrd = (state_q == S_DRD);
  assign zxuno_regwr = (state_q == S_DWR);

  always_comb begin
    oe_n = 1'b1;
    dout = 8'hFF;
    if (zxuno_regrd && src_hit) begin
      oe_n = 1'b0;
      dout = src_byte;
    end
`ifdef ZXUNO_ADDR_READBACK_EN
    if (state_q == S_ARD) begin
      oe_n = 1'b0;
      dout = zxuno_addr;
    end
`endif
  end

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
module tb_zxuno_regbus_ctrl;
  localparam int          NSRC = 4;
  localparam logic [15:0] AP   = 16'hFC3B;
  localparam logic [15:0] DP   = 16'hFD3B;
`ifdef ZXUNO_ADDR_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       a = 16'h0000;
  logic              iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]        din = 8'h00;
  logic [8*NSRC-1:0] per_dout = '0;
  logic [NSRC-1:0]   per_oe_n = '1;
  logic [7:0]        zxuno_addr, dout;
  logic              zxuno_regrd, zxuno_regwr, regaddr_changed, oe_n, conflict;

  zxuno_regbus_ctrl #(.NSRC(NSRC), .ADDR_PORT(AP), .DATA_PORT(DP)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .per_dout(per_dout), .per_oe_n(per_oe_n),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .regaddr_changed(regaddr_changed), .dout(dout), .oe_n(oe_n), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected observation for one whole I/O cycle
  typedef struct {
    int         chg;   // regaddr_changed high samples
    int         wr;    // regwr high samples
    int         rd;    // regrd high samples
    int         oe;    // oe_n low samples
    logic [7:0] dout;
    logic [7:0] addr;
    logic       conf;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  logic [7:0] m_addr = 8'h00;
  logic       m_conf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  zxuno_addr, 8'h00);
    chk({tag, "_regrd"}, zxuno_regrd, 0);
    chk({tag, "_regwr"}, zxuno_regwr, 0);
    chk({tag, "_chg"},   regaddr_changed, 0);
    chk({tag, "_conf"},  conflict, 0);
    chk({tag, "_oe_n"},  oe_n, 1);
    chk({tag, "_dout"},  dout, 8'hFF);
  endtask

  // Monitor: accumulates what the DUT presents during each I/O cycle and
  // pops/compares one expectation when iorq_n is seen high again.
  int         a_chg = 0, a_wr = 0, a_rd = 0, a_oe = 0;
  logic [7:0] a_dout = 8'h00;
  bit         a_varied = 1'b0, in_cyc = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_chg = 0; a_wr = 0; a_rd = 0; a_oe = 0; a_varied = 1'b0;
    end else if (!iorq_n || in_cyc) begin
      a_chg += int'(regaddr_changed);
      a_wr  += int'(zxuno_regwr);
      a_rd  += int'(zxuno_regrd);
      if (!oe_n) begin
        if (a_oe == 0) a_dout = dout;
        else if (dout != a_dout) a_varied = 1'b1;
        a_oe++;
      end
      if (!iorq_n) in_cyc = 1'b1;
      else begin
        exp_t e;
        in_cyc = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_cycle", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("regaddr_changed_cnt", a_chg, e.chg);
          chk("regwr_cnt", a_wr, e.wr);
          chk("regrd_cnt", a_rd, e.rd);
          chk("oe_low_cnt", a_oe, e.oe);
          if (e.oe > 0) begin
            chk("dout", a_dout, e.dout);
            chk("dout_stable", int'(a_varied), 0);
          end
          chk("zxuno_addr", zxuno_addr, e.addr);
          chk("conflict", conflict, e.conf);
        end
        a_chg = 0; a_wr = 0; a_rd = 0; a_oe = 0; a_varied = 1'b0;
      end
    end
  end

  // Model: decide from the bus cycle what the DUT must present, push it,
  // then drive the cycle. n >= 2 clocks with iorq_n low.
  task automatic run_op(input logic [15:0] port, input logic rdl, input logic wrl,
                        input logic [7:0] d, input int n, input logic [NSRC-1:0] oe,
                        input logic [8*NSRC-1:0] pd, input int gap);
    exp_t e;
    int   cnt;
    logic [7:0] first;
    e = '{chg: 0, wr: 0, rd: 0, oe: 0, dout: 8'hFF, addr: 8'h00, conf: 1'b0};
    if (port == AP && !wrl) begin
      m_addr = d; m_conf = 1'b0; e.chg = 1;
    end else if (port == DP && !wrl) begin
      e.wr = n;
    end else if (port == DP && !rdl) begin
      e.rd = n;
      cnt = 0; first = 8'hFF;
      for (int i = 0; i < NSRC; i++)
        if (!oe[i]) begin
          if (cnt == 0) first = pd[8*i +: 8];
          cnt++;
        end
      if (cnt > 0) begin e.oe = n; e.dout = first; end
      if (cnt >= 2) m_conf = 1'b1;
    end else if (port == AP && !rdl && RB) begin
      e.oe = n; e.dout = m_addr;
    end
    e.addr = m_addr; e.conf = m_conf;
    exp_q.push_back(e);

    @(posedge clk); #1;
    a = port; din = d; rd_n = rdl; wr_n = wrl; per_oe_n = oe; per_dout = pd; iorq_n = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      din = 8'($urandom);   // must be ignored once the cycle is accepted
    end
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic rand_op();
    logic [15:0] port;
    logic        rdl, wrl;
    int          sel;
    sel = int'($urandom_range(0, 9));
    port = (sel < 4) ? AP : (sel < 9) ? DP : 16'($urandom);
    sel = int'($urandom_range(0, 6));
    rdl = (sel == 1 || sel == 2) ? 1'b1 : 1'b0;  // 2/7 writes,
    wrl = (sel >= 3) ? 1'b1 : 1'b0;              // 4/7 reads, 1/7 both
    run_op(port, rdl, wrl, 8'($urandom), int'($urandom_range(2, 5)),
           4'($urandom), 32'($urandom), int'($urandom_range(0, 2)));
  endtask

  initial begin
    #12;
    chk_reset_vals("por");
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed cases
    run_op(AP, 1'b1, 1'b0, 8'hFF, 3, 4'b1111, 32'h0, 1);
    run_op(DP, 1'b0, 1'b1, 8'h00, 3, 4'b1101, 32'hAABB54CC, 1);
    run_op(DP, 1'b0, 1'b1, 8'h00, 3, 4'b1100, 32'hAABB54CC, 1);
    run_op(DP, 1'b1, 1'b0, 8'h12, 4, 4'b1111, 32'h0, 1);
    run_op(DP, 1'b0, 1'b1, 8'h00, 2, 4'b0111, 32'h11223344, 0);
    run_op(AP, 1'b1, 1'b0, 8'h0B, 2, 4'b1111, 32'h0, 0);
    run_op(AP, 1'b0, 1'b1, 8'h00, 3, 4'b1110, 32'h0, 1);
    run_op(DP, 1'b0, 1'b0, 8'h77, 3, 4'b0000, 32'h0, 1);  // write wins over read
    run_op(16'hFC3A, 1'b1, 1'b0, 8'h55, 2, 4'b1111, 32'h0, 1);

    repeat (150) rand_op();

    // Reset in the middle of a read cycle; the cycle must not be re-acted on
    m_addr = 8'h00; m_conf = 1'b0;
    exp_q.push_back('{chg: 0, wr: 0, rd: 0, oe: 0, dout: 8'hFF, addr: 8'h00, conf: 1'b0});
    @(posedge clk); #1;
    a = DP; rd_n = 1'b0; per_oe_n = 4'b0000; per_dout = 32'h01020304; iorq_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 iorq_n = 1'b1; rd_n = 1'b1;
    repeat (2) @(posedge clk);

    repeat (20) rand_op();
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
